// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer and the stage modules it drives.
package pipeline_controller_pkg;

  localparam int unsigned HOLD_CNT_W = 4;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic memwb_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } PipelineCtrl;

endpackage

// File: rtl/pipeline_perf_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipeline_perf_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage core: hazard/branch/trap priority, trap-hold FSM,
// deferred trap behind a busy data memory, hazard watchdog and performance counters.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned TRAP_HOLD_CYCLES  = 2,
  parameter int unsigned MAX_HAZARD_CYCLES = 2,
  parameter int unsigned COUNTER_WIDTH     = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_ID_hazard,
  input  logic                     i_EX_isValid,
  input  logic                     i_EX_branchTaken,
  input  logic                     i_MEM_isValid,
  input  logic                     i_MEM_trap,
  input  logic                     i_MEM_busy,
  input  logic                     i_IF_busy,
  input  logic                     i_counterClear,
  output logic                     o_PC_stall,
  output logic                     o_IFID_stall,
  output logic                     o_IDEX_stall,
  output logic                     o_EXMEM_stall,
  output logic                     o_MEMWB_stall,
  output logic                     o_IFID_flush,
  output logic                     o_IDEX_flush,
  output logic                     o_EXMEM_flush,
  output logic                     o_MEMWB_flush,
  output logic                     o_redirectBranch,
  output logic                     o_redirectTrap,
  output logic                     o_hazardTimeout,
  output logic [COUNTER_WIDTH-1:0] o_stallCount,
  output logic [COUNTER_WIDTH-1:0] o_flushCount
);

  typedef enum logic [0:0] {ST_RUN, ST_TRAP_HOLD} state_e;

  localparam int unsigned RUN_W = $clog2(MAX_HAZARD_CYCLES + 2);
  localparam logic [RUN_W-1:0] RUN_CAP = RUN_W'(MAX_HAZARD_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_HAZARD_CYCLES);

  state_e                state_q, state_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic                  pending_q, pending_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  timeout_q, timeout_d;

  PipelineCtrl ctrl;
  logic        redir_branch;
  logic        redir_trap;
  logic        trap_now;

  assign trap_now = i_MEM_trap & i_MEM_isValid;

  always_comb begin
    ctrl         = '0;
    redir_branch = 1'b0;
    redir_trap   = 1'b0;
    state_d      = state_q;
    hold_d       = hold_q;
    pending_d    = pending_q;
    if (i_reset) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      ctrl.memwb_flush = 1'b1;
      state_d          = ST_RUN;
      hold_d           = '0;
      pending_d        = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          // A trap seen while MEM is busy is parked and taken once memory frees up.
          if (i_MEM_busy) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_stall  = 1'b1;
            ctrl.exmem_stall = 1'b1;
            ctrl.memwb_flush = 1'b1;
            if (trap_now) pending_d = 1'b1;
          end else if (trap_now || pending_q) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.memwb_flush = 1'b1;
            redir_trap       = 1'b1;
            pending_d        = 1'b0;
            hold_d           = HOLD_CNT_W'(TRAP_HOLD_CYCLES);
            state_d          = ST_TRAP_HOLD;
          end else if (i_EX_branchTaken && i_EX_isValid) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            redir_branch    = 1'b1;
          end else if (i_ID_hazard) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_stall = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (i_IF_busy) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_flush = 1'b1;
          end
        end
        ST_TRAP_HOLD: begin
          ctrl.pc_stall   = 1'b1;
          ctrl.ifid_flush = 1'b1;
          if (!i_MEM_busy) begin
            if (hold_q <= HOLD_CNT_W'(1)) begin
              hold_d  = '0;
              state_d = ST_RUN;
            end else begin
              hold_d = hold_q - 1'b1;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Timeout is judged on the updated run length so it rises the cycle after the limit is passed.
  always_comb begin
    run_d = '0;
    if (i_ID_hazard) begin
      run_d = run_q;
      if ((state_q == ST_RUN) && (run_q != RUN_CAP)) run_d = run_q + 1'b1;
    end
    timeout_d = timeout_q | (run_d > RUN_MAX);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_RUN;
      hold_q    <= '0;
      pending_q <= 1'b0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  pipeline_perf_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_counterClear),
    .i_inc   (ctrl.pc_stall),
    .o_count (o_stallCount)
  );

  pipeline_perf_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_counterClear),
    .i_inc   (redir_branch | redir_trap),
    .o_count (o_flushCount)
  );

  assign o_PC_stall       = ctrl.pc_stall;
  assign o_IFID_stall     = ctrl.ifid_stall;
  assign o_IDEX_stall     = ctrl.idex_stall;
  assign o_EXMEM_stall    = ctrl.exmem_stall;
  assign o_MEMWB_stall    = ctrl.memwb_stall;
  assign o_IFID_flush     = ctrl.ifid_flush;
  assign o_IDEX_flush     = ctrl.idex_flush;
  assign o_EXMEM_flush    = ctrl.exmem_flush;
  assign o_MEMWB_flush    = ctrl.memwb_flush;
  assign o_redirectBranch = redir_branch;
  assign o_redirectTrap   = redir_trap;
  assign o_hazardTimeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench: the driver queues hand-computed per-cycle expectations, a negedge monitor checks them.
module tb_pipeline_controller;

  localparam int unsigned CW = 4;

  // Input pattern bits: {rst, hazard, ex_valid, branch, mem_valid, mem_trap, mem_busy, if_busy, clr}
  localparam logic [8:0] I_NONE = 9'h000;
  localparam logic [8:0] I_RST  = 9'h100;
  localparam logic [8:0] I_HZ   = 9'h080;
  localparam logic [8:0] I_BR   = 9'h060;
  localparam logic [8:0] I_TRAP = 9'h018;
  localparam logic [8:0] I_MB   = 9'h004;
  localparam logic [8:0] I_IB   = 9'h002;
  localparam logic [8:0] I_CLR  = 9'h001;

  // Control bits: {pc_st, ifid_st, idex_st, exmem_st, memwb_st, ifid_fl, idex_fl, exmem_fl, memwb_fl, rbr, rtrap}
  localparam logic [10:0] C_NONE = 11'b0_0000_0000_00;
  localparam logic [10:0] C_RST  = 11'b0_0000_1111_00;
  localparam logic [10:0] C_HAZ  = 11'b1_1000_0100_00;
  localparam logic [10:0] C_BR   = 11'b0_0000_1100_10;
  localparam logic [10:0] C_TRAP = 11'b0_0000_1111_01;
  localparam logic [10:0] C_HOLD = 11'b1_0000_1000_00;
  localparam logic [10:0] C_BUSY = 11'b1_1110_0001_00;
  localparam logic [10:0] C_IFB  = 11'b1_0000_1000_00;

  typedef struct {
    int          tag;
    logic [10:0] ctrl;
    bit          chk;
    logic        tmo;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk = 1'b1;
  logic rst, hz, exv, br, mv, mt, mb, ib, clr;
  logic pc_st, ifid_st, idex_st, exmem_st, memwb_st;
  logic ifid_fl, idex_fl, exmem_fl, memwb_fl, rbr, rtrap, tmo;
  logic [CW-1:0] sc, fc;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   tag    = 0;

  always #5 clk = ~clk;

  pipeline_controller #(
    .TRAP_HOLD_CYCLES (2),
    .MAX_HAZARD_CYCLES(2),
    .COUNTER_WIDTH    (CW)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_ID_hazard     (hz),
    .i_EX_isValid    (exv),
    .i_EX_branchTaken(br),
    .i_MEM_isValid   (mv),
    .i_MEM_trap      (mt),
    .i_MEM_busy      (mb),
    .i_IF_busy       (ib),
    .i_counterClear  (clr),
    .o_PC_stall      (pc_st),
    .o_IFID_stall    (ifid_st),
    .o_IDEX_stall    (idex_st),
    .o_EXMEM_stall   (exmem_st),
    .o_MEMWB_stall   (memwb_st),
    .o_IFID_flush    (ifid_fl),
    .o_IDEX_flush    (idex_fl),
    .o_EXMEM_flush   (exmem_fl),
    .o_MEMWB_flush   (memwb_fl),
    .o_redirectBranch(rbr),
    .o_redirectTrap  (rtrap),
    .o_hazardTimeout (tmo),
    .o_stallCount    (sc),
    .o_flushCount    (fc)
  );

  task automatic step(input logic [8:0] ins, input logic [10:0] c, input bit chk,
                      input logic t, input int s, input int f);
    exp_t e;
    {rst, hz, exv, br, mv, mt, mb, ib, clr} = ins;
    tag++;
    e.tag = tag; e.ctrl = c; e.chk = chk; e.tmo = t;
    e.sc = CW'(s); e.fc = CW'(f);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [10:0] got;
      e = q.pop_front();
      got = {pc_st, ifid_st, idex_st, exmem_st, memwb_st,
             ifid_fl, idex_fl, exmem_fl, memwb_fl, rbr, rtrap};
      n_cmp++;
      if (got !== e.ctrl) begin
        n_fail++;
        $display("FAIL v%0d ctrl: got %b want %b", e.tag, got, e.ctrl);
      end
      if (e.chk) begin
        n_cmp++;
        if (tmo !== e.tmo) begin
          n_fail++;
          $display("FAIL v%0d timeout: got %b want %b", e.tag, tmo, e.tmo);
        end
        n_cmp++;
        if (sc !== e.sc) begin
          n_fail++;
          $display("FAIL v%0d stallCount: got %0d want %0d", e.tag, sc, e.sc);
        end
        n_cmp++;
        if (fc !== e.fc) begin
          n_fail++;
          $display("FAIL v%0d flushCount: got %0d want %0d", e.tag, fc, e.fc);
        end
      end
    end
  end

  initial begin
    // reset for 3 cycles, then idle
    step(I_RST, C_RST, 0, 0, 0, 0);
    step(I_RST, C_RST, 1, 0, 0, 0);
    step(I_RST, C_RST, 1, 0, 0, 0);
    step(I_NONE, C_NONE, 1, 0, 0, 0);
    // single-cycle load-use hazard
    step(I_HZ, C_HAZ, 1, 0, 0, 0);
    step(I_NONE, C_NONE, 1, 0, 1, 0);
    // branch beats hazard
    step(I_HZ | I_BR, C_BR, 1, 0, 1, 0);
    step(I_NONE, C_NONE, 1, 0, 1, 1);
    // trap then two hold cycles
    step(I_TRAP, C_TRAP, 1, 0, 1, 1);
    step(I_NONE, C_HOLD, 1, 0, 1, 2);
    step(I_NONE, C_HOLD, 1, 0, 2, 2);
    step(I_NONE, C_NONE, 1, 0, 3, 2);
    // trap behind a busy data memory, taken from the pending latch
    step(I_MB | I_TRAP, C_BUSY, 1, 0, 3, 2);
    step(I_MB, C_BUSY, 1, 0, 4, 2);
    step(I_MB, C_BUSY, 1, 0, 5, 2);
    step(I_NONE, C_TRAP, 1, 0, 6, 2);
    // busy during hold freezes the hold counter -> three hold cycles
    step(I_NONE, C_HOLD, 1, 0, 6, 3);
    step(I_MB, C_HOLD, 1, 0, 7, 3);
    step(I_NONE, C_HOLD, 1, 0, 8, 3);
    step(I_NONE, C_NONE, 1, 0, 9, 3);
    // trap beats branch; branch/hazard ignored in hold
    step(I_TRAP | I_BR, C_TRAP, 1, 0, 9, 3);
    step(I_HZ | I_BR, C_HOLD, 1, 0, 9, 4);
    step(I_NONE, C_HOLD, 1, 0, 10, 4);
    step(I_NONE, C_NONE, 1, 0, 11, 4);
    // instruction memory busy
    step(I_IB, C_IFB, 1, 0, 11, 4);
    step(I_NONE, C_NONE, 1, 0, 12, 4);
    // counter clear
    step(I_CLR, C_NONE, 1, 0, 12, 4);
    step(I_NONE, C_NONE, 1, 0, 0, 0);
    // hazard held 3 cycles trips the watchdog
    step(I_HZ, C_HAZ, 1, 0, 0, 0);
    step(I_HZ, C_HAZ, 1, 0, 1, 0);
    step(I_HZ, C_HAZ, 1, 0, 2, 0);
    step(I_NONE, C_NONE, 1, 1, 3, 0);
    step(I_NONE, C_NONE, 1, 1, 3, 0);
    // 20 stall cycles saturate a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      step(I_IB, C_IFB, 1, 1, ((3 + k) > 15) ? 15 : (3 + k), 0);
    end
    step(I_NONE, C_NONE, 1, 1, 15, 0);
    // reset in the middle of a trap hold
    step(I_TRAP, C_TRAP, 1, 1, 15, 0);
    step(I_RST, C_RST, 1, 1, 15, 1);
    step(I_NONE, C_NONE, 1, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
